dft_tree_fault_profiler: RTL and testbench
==========================================

// Module: dft_tree_fault_profiler
// PURPOSE
//  Parametrised AND-reduction tree (N_IN leaves) with per-node control point and per-node stuck-at
//  injection. A built-in sequencer sweeps every stuck-at fault over LFSR patterns, compares the faulty
//  tree against a fault-free golden copy, and counts detected faults.
//  Successor to the fixed 16-input tree with one control point and one fixed fault site.
//  Sits in the testability-profiling flow; also usable in manual mode from tb or test controller.
// PARAMETERS
//  N_IN      16       tree inputs; power of two, >=4. NODES = N_IN-1, L1 = N_IN/2, IW = clog2(NODES)
//  PATTERNS  64       LFSR patterns applied per fault, >=1
//  LFSR_TAPS 16'hB400 Galois feedback mask, N_IN bits (maximal length for 16); N_IN=4 uses 4'hC
//  SEED      all-1s   LFSR seed reloaded per fault; a zero seed is replaced by 1
//  CNT_W     16       width of det_count / undet_count; must hold 2*NODES
// PORTS
//  clk          in  1      rising-edge clock
//  rst_n        in  1      asynchronous active-low reset
//  in           in  N_IN   tree inputs, manual mode only
//  test_mode    in  1      enables the control point
//  cp_en        in  1      control-point request; effective only with test_mode=1
//  cp_node      in  IW     node forced to 1 by the control point
//  fault_en     in  1      manual fault enable; ignored while busy
//  fault_node   in  IW     manual fault site
//  fault_type   in  1      0=SA0, 1=SA1
//  start        in  1      one-cycle pulse; starts a profile run; ignored while busy
//  out          out 1      faulty-tree root
//  golden_out   out 1      fault-free-tree root
//  obs_point    out L1     faulty-tree level-1 node values (observation points)
//  mismatch     out 1      out != golden_out (comb)
//  busy         out 1      profile run in progress
//  done         out 1      1-cycle pulse at end of run
//  det_count    out CNT_W  faults detected in last run
//  undet_count  out CNT_W  faults not detected in last run
// BEHAVIOUR
//  - Heap indexing: node 0 = root; node i = node(2i+1) & node(2i+2).
//    Leaf node L1-1+j = in[2j+1] & in[2j]. Lower child covers lower bits.
//  - Node value = AND of children, then the CP mux, then the fault mux. A fault wins over CP on the same node.
//  - CP: when test_mode && cp_en, node cp_node = 1 in BOTH trees. cp_node >= NODES: no effect.
//  - Fault: the faulty tree only; node forced to fault_type. Out-of-range node: no effect.
//  - Tree datapath is combinational. Tree inputs = in when idle, LFSR state when busy.
//    Fault source = fault_* ports when idle, sequencer when busy.
//  - FSM IDLE -> APPLY -> NEXT -> (APPLY | DONE) -> IDLE.
//    IDLE + start:
//      - clear counts, set fault index = node 0 / SA0, load LFSR = SEED, pat = 0, det_flag = 0.
//    APPLY: each cycle
//      - det_flag |= mismatch; LFSR steps; pat++.
//      - After PATTERNS cycles -> NEXT.
//    NEXT (1 cycle):
//      - det_count++ if det_flag, else undet_count++.
//      - Advance fault: SA0 -> SA1 same node, then next node SA0.
//      - Reload SEED, clear det_flag and pat.
//      - Last fault (node NODES-1, SA1) -> DONE.
//    DONE (1 cycle): done=1, then IDLE.
//  - busy = 1 in APPLY/NEXT/DONE. Run length = 2*NODES*(PATTERNS+1)+1 cycles after the start edge.
//  - Counts hold until the next start; det_count + undet_count = 2*NODES at done.
//  - Reset values: busy=0, done=0, counts=0, LFSR=SEED, FSM=IDLE. out/golden/obs follow in.
//  - Reset mid-run aborts immediately: no done pulse; counts read 0.
//  - start while busy: ignored. start in the DONE cycle: ignored.
// CONFIGURATION
//  OBS_CMP_EN defined:
//    - Detection also samples obs_point != golden level-1 values each APPLY cycle.
//    - The obs mismatch is ORed into det_flag.
//  OBS_CMP_EN undefined:
//    - Detection uses the root mismatch only.
//    - No golden level-1 compare logic is generated.
//  Manual-mode outputs are identical in both builds.
// TESTING (N_IN=16 unless stated)
//  1. Manual, in=16'hFFFF, fault_en=0 -> out=1, golden_out=1, mismatch=0, obs_point=8'hFF.
//  2. Manual, in=16'hFFFF, fault_en=1, node 0, SA0 -> out=0, golden_out=1, mismatch=1.
//  3. CP, in=16'hFFF0, test_mode=1, cp_en=1, cp_node=3:
//     - out=1 and golden_out=1.
//     - test_mode=0 -> both 0.
//     - Add fault node 3 SA0 -> out=0, golden_out=1.
//  4. Profile, N_IN=4, PATTERNS=15, TAPS=4'hC, SEED=4'hF:
//     - done exactly 97 cycles after start; det_count=6, undet_count=0.
//     - busy=1 throughout.
//  5. Profile, N_IN=4, PATTERNS=1, SEED=4'h3:
//     - Macro undefined -> det_count=2, undet_count=4.
//     - OBS_CMP_EN defined -> det_count=3, undet_count=3.
//  6. rst_n low at cycle 20 of a run:
//     - busy=0, counts=0, no done pulse.
//     - A fresh start then completes with the same counts as an uninterrupted run.
//     - A start pulse mid-run is ignored.

Source files
------------

// File: rtl/dft_tree_fault_profiler.sv
// AND-reduction tree with per-node control point and stuck-at injection, plus a fault-sweep
// profiler against a fault-free golden copy. Define OBS_CMP_EN to also detect via level-1 observation points.
module dft_tree_fault_profiler #(
    parameter int              N_IN      = 16,
    parameter int              PATTERNS  = 64,
    parameter logic [N_IN-1:0] LFSR_TAPS = N_IN'(16'hB400),
    parameter logic [N_IN-1:0] SEED      = '1,
    parameter int              CNT_W     = 16,
    localparam int             NODES     = N_IN - 1,
    localparam int             L1        = N_IN / 2,
    localparam int             IW        = $clog2(NODES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in,
    input  logic             test_mode,
    input  logic             cp_en,
    input  logic [IW-1:0]    cp_node,
    input  logic             fault_en,
    input  logic [IW-1:0]    fault_node,
    input  logic             fault_type,
    input  logic             start,
    output logic             out,
    output logic             golden_out,
    output logic [L1-1:0]    obs_point,
    output logic             mismatch,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] det_count,
    output logic [CNT_W-1:0] undet_count
);

    localparam int              LV       = $clog2(N_IN);
    localparam int              PW       = $clog2(PATTERNS) + 1;
    localparam logic [N_IN-1:0] SEED_EFF = (SEED == '0) ? N_IN'(1) : SEED;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_NEXT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [N_IN-1:0]   lfsr;
    logic [PW-1:0]     pat;
    logic [IW-1:0]     seq_node;
    logic              seq_type;
    logic              det_flag;

    logic [N_IN-1:0]   tin;
    logic              cp_on, f_en, f_val, det_hit;
    logic [IW-1:0]     f_node;
    logic [N_IN-1:0]   lfsr_step;
    logic              pat_last, last_fault;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // While profiling, the LFSR drives the leaves and the sequencer owns the fault site.
    assign tin    = busy ? lfsr : in;
    assign cp_on  = test_mode & cp_en;
    assign f_en   = busy | fault_en;
    assign f_node = busy ? seq_node : fault_node;
    assign f_val  = busy ? seq_type : fault_type;

    // Level l holds heap nodes 2^l-1 .. 2^(l+1)-2; child 2i+1 (lower bits) sits at position 2k below.
    for (genvar l = 0; l < LV; l++) begin : lvl
        localparam int W = 1 << l;
        logic [W-1:0] fv, gv;
        for (genvar k = 0; k < W; k++) begin : nd
            localparam int IDX = W - 1 + k;
            logic a_f, b_f, a_g, b_g, cp_hit, flt_hit;
            if (l == LV - 1) begin : leaf
                assign a_f = tin[2*k];
                assign b_f = tin[2*k+1];
                assign a_g = tin[2*k];
                assign b_g = tin[2*k+1];
            end else begin : inner
                assign a_f = lvl[l+1].fv[2*k];
                assign b_f = lvl[l+1].fv[2*k+1];
                assign a_g = lvl[l+1].gv[2*k];
                assign b_g = lvl[l+1].gv[2*k+1];
            end
            assign cp_hit  = cp_on && (cp_node == IW'(IDX));
            assign flt_hit = f_en && (f_node == IW'(IDX));
            assign gv[k]   = (a_g & b_g) | cp_hit;
            assign fv[k]   = flt_hit ? f_val : ((a_f & b_f) | cp_hit);
        end
    end

    assign out        = lvl[0].fv[0];
    assign golden_out = lvl[0].gv[0];
    assign obs_point  = lvl[LV-1].fv;
    assign mismatch   = out ^ golden_out;

`ifdef OBS_CMP_EN
    assign det_hit = mismatch | (|(obs_point ^ lvl[LV-1].gv));
`else
    assign det_hit = mismatch;
`endif

    assign lfsr_step  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign pat_last   = (pat == PW'(PATTERNS - 1));
    assign last_fault = (seq_node == IW'(NODES - 1)) && seq_type;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_APPLY;
            S_APPLY: if (pat_last) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = last_fault ? S_DONE : S_APPLY;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr        <= SEED_EFF;
            pat         <= '0;
            seq_node    <= '0;
            seq_type    <= 1'b0;
            det_flag    <= 1'b0;
            det_count   <= '0;
            undet_count <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    det_count   <= '0;
                    undet_count <= '0;
                    seq_node    <= '0;
                    seq_type    <= 1'b0;
                    lfsr        <= SEED_EFF;
                    pat         <= '0;
                    det_flag    <= 1'b0;
                end
                S_APPLY: begin
                    det_flag <= det_flag | det_hit;
                    lfsr     <= lfsr_step;
                    pat      <= pat + PW'(1);
                end
                S_NEXT: begin
                    if (det_flag) det_count   <= det_count + CNT_W'(1);
                    else          undet_count <= undet_count + CNT_W'(1);
                    // Fault order: SA0 then SA1 on a node, then the next node.
                    if (!last_fault) begin
                        if (seq_type) begin
                            seq_node <= seq_node + IW'(1);
                            seq_type <= 1'b0;
                        end else begin
                            seq_type <= 1'b1;
                        end
                    end
                    lfsr     <= SEED_EFF;
                    det_flag <= 1'b0;
                    pat      <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dft_tree_fault_profiler.sv
// Bench for dft_tree_fault_profiler: random manual-mode patterns and profile runs checked against a
// heap-indexed behavioural tree model; N_IN=4 profile instances cover the fixed-count scenarios.
module tb_dft_tree_fault_profiler;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [15:0] in16;
    logic        tm, cpe, fe, ft;
    logic [3:0]  cpn, fn;
    logic [2:0]  st;
    logic [3:0]  in4;

    logic        o16, g16, mm16, b16, d16;
    logic [7:0]  obs16;
    logic [15:0] det16, und16;
    logic        oA, gA, mmA, bA, dA;
    logic [1:0]  obsA;
    logic [15:0] detA, undA;
    logic        oB, gB, mmB, bB, dB;
    logic [1:0]  obsB;
    logic [15:0] detB, undB;

    logic [2:0] bsy, dn;
    assign bsy = {bB, bA, b16};
    assign dn  = {dB, dA, d16};

`ifdef OBS_CMP_EN
    localparam int T5_DET = 3, T5_UND = 3;
`else
    localparam int T5_DET = 2, T5_UND = 4;
`endif

    dft_tree_fault_profiler u16 (
        .clk(clk), .rst_n(rst_n), .in(in16), .test_mode(tm), .cp_en(cpe), .cp_node(cpn),
        .fault_en(fe), .fault_node(fn), .fault_type(ft), .start(st[0]),
        .out(o16), .golden_out(g16), .obs_point(obs16), .mismatch(mm16), .busy(b16), .done(d16),
        .det_count(det16), .undet_count(und16));

    dft_tree_fault_profiler #(.N_IN(4), .PATTERNS(15), .LFSR_TAPS(4'hC), .SEED(4'hF)) u4a (
        .clk(clk), .rst_n(rst_n), .in(in4), .test_mode(1'b0), .cp_en(1'b0), .cp_node(2'b00),
        .fault_en(1'b0), .fault_node(2'b00), .fault_type(1'b0), .start(st[1]),
        .out(oA), .golden_out(gA), .obs_point(obsA), .mismatch(mmA), .busy(bA), .done(dA),
        .det_count(detA), .undet_count(undA));

    dft_tree_fault_profiler #(.N_IN(4), .PATTERNS(1), .LFSR_TAPS(4'hC), .SEED(4'h3)) u4b (
        .clk(clk), .rst_n(rst_n), .in(in4), .test_mode(1'b0), .cp_en(1'b0), .cp_node(2'b00),
        .fault_en(1'b0), .fault_node(2'b00), .fault_type(1'b0), .start(st[2]),
        .out(oB), .golden_out(gB), .obs_point(obsB), .mismatch(mmB), .busy(bB), .done(dB),
        .det_count(detB), .undet_count(undB));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference tree evaluated bottom-up on heap indices.
    function automatic void tree_model(input int n, input logic [15:0] vin, input bit cpon,
                                       input int cpnode, input bit fon, input int fnode, input bit ftype,
                                       output bit rf, output bit rg,
                                       output logic [7:0] l1f, output logic [7:0] l1g);
        bit vf[0:14];
        bit vg[0:14];
        bit af, bf, ag, bg;
        int l1;
        l1 = n / 2;
        for (int i = n - 2; i >= 0; i--) begin
            if (i >= l1 - 1) begin
                af = vin[2*(i-l1+1)];
                bf = vin[2*(i-l1+1)+1];
                ag = af;
                bg = bf;
            end else begin
                af = vf[2*i+1]; bf = vf[2*i+2];
                ag = vg[2*i+1]; bg = vg[2*i+2];
            end
            vg[i] = (ag & bg) | (cpon && cpnode == i);
            vf[i] = (af & bf) | (cpon && cpnode == i);
            if (fon && fnode == i) vf[i] = ftype;
        end
        rf = vf[0];
        rg = vg[0];
        l1f = '0;
        l1g = '0;
        for (int j = 0; j < l1; j++) begin
            l1f[j] = vf[l1-1+j];
            l1g[j] = vg[l1-1+j];
        end
    endfunction

    function automatic void prof_model(input int n, input int pats, input logic [15:0] taps,
                                       input logic [15:0] seed, input bit cpon, input int cpnode,
                                       output int det, output int und);
        logic [15:0] s;
        bit hit, rf, rg;
        logic [7:0] lf, lg;
        det = 0;
        und = 0;
        for (int node = 0; node < n - 1; node++) begin
            for (int t = 0; t < 2; t++) begin
                s   = (seed == 16'h0) ? 16'h1 : seed;
                hit = 1'b0;
                for (int p = 0; p < pats; p++) begin
                    tree_model(n, s, cpon, cpnode, 1'b1, node, (t == 1), rf, rg, lf, lg);
                    hit = hit | (rf != rg);
`ifdef OBS_CMP_EN
                    hit = hit | (lf != lg);
`endif
                    s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
                end
                if (hit) det++;
                else     und++;
            end
        end
    endfunction

    task automatic check_manual(input string tag);
        bit rf, rg;
        logic [7:0] lf, lg;
        #1;
        tree_model(16, in16, tm && cpe, int'(cpn), fe, int'(fn), ft, rf, rg, lf, lg);
        chk({tag, ".out"}, o16, rf);
        chk({tag, ".golden"}, g16, rg);
        chk({tag, ".mismatch"}, mm16, rf ^ rg);
        chk({tag, ".obs"}, obs16, lf);
    endtask

    // Pulses start, then counts busy cycles; optionally re-pulses start at busy cycle poke_at.
    task automatic run_prof(input int id, input int poke_at, input int max_cyc,
                            output int cyc, output int dones, output bit done_last);
        @(posedge clk); #1 st[id] = 1'b1;
        @(posedge clk); #1 st[id] = 1'b0;
        cyc = 0;
        dones = 0;
        done_last = 1'b0;
        while (bsy[id] && cyc < max_cyc) begin
            cyc++;
            done_last = dn[id];
            if (dn[id]) dones++;
            st[id] = (cyc == poke_at);
            @(posedge clk); #1;
        end
        st[id] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, dones, edet, eund, dcnt;
        bit dlast;

        rst_n = 1'b0;
        in16 = 16'hFFFF; in4 = 4'h0;
        tm = 0; cpe = 0; cpn = 0; fe = 0; fn = 0; ft = 0; st = '0;
        #12;
        chk("rst.busy16", b16, 0);
        chk("rst.done16", d16, 0);
        chk("rst.det16", det16, 0);
        chk("rst.und16", und16, 0);
        chk("rst.busyA", bA, 0);
        chk("rst.out16", o16, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed manual cases
        in16 = 16'hFFFF;
        #1;
        chk("t1.out", o16, 1); chk("t1.golden", g16, 1);
        chk("t1.mm", mm16, 0); chk("t1.obs", obs16, 8'hFF);
        fe = 1; fn = 0; ft = 0;
        #1;
        chk("t2.out", o16, 0); chk("t2.golden", g16, 1); chk("t2.mm", mm16, 1);
        fn = 4'd15;
        #1;
        chk("oor_fault.out", o16, 1);
        fe = 0; in16 = 16'hFFF0; tm = 1; cpe = 1; cpn = 4'd3;
        #1;
        chk("t3.cp.out", o16, 1); chk("t3.cp.golden", g16, 1);
        tm = 0;
        #1;
        chk("t3.tm0.out", o16, 0); chk("t3.tm0.golden", g16, 0);
        tm = 1; fe = 1; fn = 4'd3; ft = 0;
        #1;
        chk("t3.flt.out", o16, 0); chk("t3.flt.golden", g16, 1);

        // Randomized manual patterns
        for (int it = 0; it < 40; it++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 2))
                0:       in16 = 16'hFFFF;
                1:       in16 = ~(16'h1 << $urandom_range(0, 15));
                default: in16 = 16'($urandom);
            endcase
            tm  = 1'($urandom); cpe = 1'($urandom); cpn = 4'($urandom);
            fe  = 1'($urandom); fn  = 4'($urandom); ft  = 1'($urandom);
            in4 = 4'($urandom);
            check_manual($sformatf("rnd%0d", it));
            chk("rnd4.out", oA, &in4);
            chk("rnd4.obs", obsA, {&in4[3:2], &in4[1:0]});
        end

        // Profile of the 4-input tree; start pulse in the DONE cycle must be ignored
        run_prof(1, 97, 200, cyc, dones, dlast);
        chk("t4.len", cyc, 97);
        chk("t4.dones", dones, 1);
        chk("t4.done_last", dlast, 1);
        chk("t4.det", detA, 6);
        chk("t4.und", undA, 0);
        @(posedge clk); #1;
        chk("t4.start_in_done", bA, 0);

        // Start pulse mid-run is ignored
        run_prof(1, 30, 200, cyc, dones, dlast);
        chk("t6.ign.len", cyc, 97);
        chk("t6.ign.det", detA, 6);
        chk("t6.ign.und", undA, 0);

        // Reset mid-run
        @(posedge clk); #1 st[1] = 1'b1;
        @(posedge clk); #1 st[1] = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.rst.busy", bA, 0);
        chk("t6.rst.det", detA, 0);
        chk("t6.rst.und", undA, 0);
        dcnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (dA) dcnt++;
        end
        chk("t6.rst.no_done", dcnt, 0);
        rst_n = 1'b1;
        run_prof(1, 0, 200, cyc, dones, dlast);
        chk("t6.fresh.len", cyc, 97);
        chk("t6.fresh.det", detA, 6);
        chk("t6.fresh.und", undA, 0);

        // Single-pattern profile
        run_prof(2, 0, 100, cyc, dones, dlast);
        chk("t5.len", cyc, 2 * 3 * 2 + 1);
        chk("t5.det", detB, T5_DET);
        chk("t5.und", undB, T5_UND);
        chk("t5.sum", detB + undB, 6);

        // Default 16-input profile with random control point; manual fault ports must be ignored
        for (int r = 0; r < 2; r++) begin
            tm  = 1'($urandom); cpe = 1'($urandom); cpn = 4'($urandom);
            fe  = 1'($urandom); fn  = 4'($urandom); ft  = 1'($urandom);
            in16 = 16'($urandom);
            prof_model(16, 64, 16'hB400, 16'hFFFF, tm && cpe, int'(cpn), edet, eund);
            run_prof(0, 0, 3000, cyc, dones, dlast);
            chk("p16.len", cyc, 2 * 15 * 65 + 1);
            chk("p16.dones", dones, 1);
            chk("p16.det", det16, edet);
            chk("p16.und", und16, eund);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
